reservoir_input_sequencer: RTL and testbench
============================================

// Module: reservoir_input_sequencer
// PURPOSE
//  Upstream feed stage of the DFR core. On start, reads NUM samples from input memory, applies a binary input
//  mask per virtual node (x or -x), streams VIRTUAL_NODES values per sample into the reservoir, and writes each
//  reservoir output into reservoir history memory at sample*VIRTUAL_NODES+node. Sits between input_mem and
//  reservoir / reservoir_output_mem; driven by dfr_core_controller.
// PARAMETERS
//  ADDR_WIDTH     14   input/history memory address width
//  DATA_WIDTH     32   sample width, signed two's complement
//  VIRTUAL_NODES  10   reservoir values per sample (>=1)
//  RES_LATENCY    1    cycles from reservoir_en/din to valid reservoir_dout (>=1)
// PORTS
//  clk             in   1             clock
//  rst             in   1             synchronous reset, active high
//  start           in   1             start pulse; sampled only in IDLE
//  num_samples     in   ADDR_WIDTH    samples to process; latched at start
//  mask            in   VIRTUAL_NODES bit n=1 -> +x, 0 -> -x for node n; latched at start
//  busy            out  1             high from cycle after accepted start until done
//  done            out  1             one-cycle pulse at completion
//  in_mem_addr     out  ADDR_WIDTH    input memory read address
//  in_mem_dout     in   DATA_WIDTH    input memory read data, 1-cycle synchronous read
//  reservoir_din   out  DATA_WIDTH    masked sample to reservoir
//  reservoir_en    out  1             reservoir advance strobe
//  reservoir_dout  in   DATA_WIDTH    reservoir output
//  hist_addr       out  ADDR_WIDTH    history memory write address
//  hist_din        out  DATA_WIDTH    history write data (= reservoir_dout)
//  hist_wen        out  1             history write enable
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters 0, delay line cleared. Mid-operation reset aborts immediately;
//   in-flight writes dropped, no done pulse.
//  FSM: IDLE -> (start & num_samples!=0) FETCH; (start & num_samples==0) DONE.
//   FETCH: drive in_mem_addr=sample_idx, 1 cycle -> LOAD.
//   LOAD: capture in_mem_dout into sample reg, 1 cycle -> INJECT.
//   INJECT: VIRTUAL_NODES cycles, reservoir_en=1, node_idx 0..VN-1; din = mask[node]? x : -x.
//    Last node: sample_idx==num_samples-1 -> DRAIN else sample_idx++ -> FETCH.
//   DRAIN: RES_LATENCY cycles until delay line empty -> DONE. DONE: done=1 one cycle -> IDLE.
//  Per sample: VIRTUAL_NODES+2 cycles. Total start->done = 1+N*(VN+2)+RES_LATENCY+1 cycles (N>0); 2 cycles (N=0).
//  Negation: -x two's complement; x=most negative saturates to max positive (0x7FFFFFFF at 32b).
//  Write path: reservoir_en delayed RES_LATENCY cycles -> hist_wen; hist_din=reservoir_dout that cycle;
//   hist_addr = write counter, 0 at start, +1 per write (equals sample*VN+node). Counter wraps mod 2^ADDR_WIDTH;
//   caller keeps N*VN <= 2^ADDR_WIDTH.
//  start while busy ignored; mask/num_samples changes while busy ignored.
//  in_mem_addr holds last value outside FETCH; reservoir_din 0 when reservoir_en=0.
// STRUCTURE
//  dfr_pkg: seq_state_t enum {IDLE,FETCH,LOAD,INJECT,DRAIN,DONE}; saturating-negate function.
//  Sub-module pipe_delay #(DEPTH=RES_LATENCY,WIDTH=1): shift register for en -> wen alignment.
// TESTING
//  N=3, VN=10, mask=all 1, in_mem={1,2,3} -> 30 writes, addr 0..29, din seq 1x10,2x10,3x10 (identity reservoir).
//  mask=10'b0101010101, x=5 -> reservoir_din alternates 5,-5 starting node0=+5; 0x80000000 -> 0x7FFFFFFF.
//  num_samples=0 -> done 2 cycles after start, busy never high, no hist_wen, no reservoir_en.
//  start pulsed again mid-run, mask changed mid-run -> ignored; output identical to clean run; cycle count exact.
//  rst at cycle 15 of N=5 run -> all outputs 0 next cycle, no further writes, no done; restart completes normally.
//  RES_LATENCY=3 -> hist_wen trails reservoir_en by 3 cycles; last write precedes done; total cycles per formula.

Source files
------------

// File: rtl/dfr_pkg.sv
// Shared types and helpers for the DFR core front end.
//   seq_state_t : input sequencer FSM states
//   sat_neg     : two's complement negate that saturates the most negative
//                 value of a w-bit word to the most positive one
package dfr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    INJECT,
    DRAIN,
    DONE
  } seq_state_t;

  // Operates on a sign-extended 64-bit container so any width up to 64 works;
  // the caller truncates the result back to w bits.
  function automatic logic [63:0] sat_neg(input logic signed [63:0] x,
                                          input int unsigned       w);
    logic signed [63:0] one;
    logic signed [63:0] min_v;
    one   = 64'sd1;
    min_v = -(one <<< (w - 1));
    if (x == min_v) begin
      return (one <<< (w - 1)) - one;
    end
    return -x;
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-latency shift register (DEPTH >= 1 stages), cleared by reset.
//   clk, rst : clock, synchronous active-high reset
//   d_i      : input word
//   q_o      : d_i delayed by DEPTH cycles
module pipe_delay #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/reservoir_input_sequencer.sv
// Feeds masked input samples into the reservoir and records every reservoir
// output into history memory at sample*VIRTUAL_NODES+node.
//   clk, rst        : clock, synchronous active-high reset
//   start           : run request, accepted only when idle
//   num_samples     : samples per run (latched at start)
//   mask            : per-node sign mask, 1 -> +x, 0 -> -x (latched at start)
//   busy, done      : run in progress / one-cycle completion pulse
//   in_mem_addr     : input memory address; in_mem_dout arrives one cycle later
//   reservoir_din   : masked sample, reservoir_en : reservoir advance strobe
//   reservoir_dout  : reservoir result, valid RES_LATENCY cycles after the strobe
//   hist_addr/din/wen : history memory write port
module reservoir_input_sequencer
  import dfr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 14,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned VIRTUAL_NODES = 10,
  parameter int unsigned RES_LATENCY   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    num_samples,
  input  logic [VIRTUAL_NODES-1:0] mask,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_WIDTH-1:0]    in_mem_addr,
  input  logic [DATA_WIDTH-1:0]    in_mem_dout,
  output logic [DATA_WIDTH-1:0]    reservoir_din,
  output logic                     reservoir_en,
  input  logic [DATA_WIDTH-1:0]    reservoir_dout,
  output logic [ADDR_WIDTH-1:0]    hist_addr,
  output logic [DATA_WIDTH-1:0]    hist_din,
  output logic                     hist_wen
);

  localparam int unsigned NODE_W  = (VIRTUAL_NODES > 1) ? $clog2(VIRTUAL_NODES) : 1;
  localparam int unsigned DRAIN_W = (RES_LATENCY > 1) ? $clog2(RES_LATENCY) : 1;
  localparam logic [NODE_W-1:0]  LAST_NODE  = NODE_W'(VIRTUAL_NODES - 1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(RES_LATENCY - 1);

  seq_state_t               state_q, state_d;
  logic [ADDR_WIDTH-1:0]    sample_idx_q, sample_idx_d;
  logic [NODE_W-1:0]        node_idx_q, node_idx_d;
  logic [DRAIN_W-1:0]       drain_cnt_q, drain_cnt_d;
  logic [ADDR_WIDTH-1:0]    num_q, num_d;
  logic [VIRTUAL_NODES-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0]    sample_q, sample_d;
  logic [ADDR_WIDTH-1:0]    in_mem_addr_q, in_mem_addr_d;
  logic                     res_en_q, res_en_d;
  logic [DATA_WIDTH-1:0]    res_din_q, res_din_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [ADDR_WIDTH-1:0]    wr_cnt_q, wr_cnt_d;
  logic                     hist_wen_w;

  // Next state, plus outputs registered from the next state so they line up
  // with the state they belong to.
  always_comb begin
    state_d       = state_q;
    sample_idx_d  = sample_idx_q;
    node_idx_d    = node_idx_q;
    drain_cnt_d   = drain_cnt_q;
    num_d         = num_q;
    mask_d        = mask_q;
    sample_d      = sample_q;
    in_mem_addr_d = in_mem_addr_q;
    res_en_d      = 1'b0;
    res_din_d     = '0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    wr_cnt_d      = hist_wen_w ? wr_cnt_q + ADDR_WIDTH'(1) : wr_cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          num_d        = num_samples;
          mask_d       = mask;
          sample_idx_d = '0;
          node_idx_d   = '0;
          wr_cnt_d     = '0;
          state_d      = (num_samples != '0) ? FETCH : DONE;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        sample_d   = in_mem_dout;
        node_idx_d = '0;
        state_d    = INJECT;
      end
      INJECT: begin
        if (node_idx_q == LAST_NODE) begin
          node_idx_d = '0;
          if (sample_idx_q == num_q - ADDR_WIDTH'(1)) begin
            drain_cnt_d = '0;
            state_d     = DRAIN;
          end else begin
            sample_idx_d = sample_idx_q + ADDR_WIDTH'(1);
            state_d      = FETCH;
          end
        end else begin
          node_idx_d = node_idx_q + NODE_W'(1);
        end
      end
      DRAIN: begin
        // Wait out the reservoir latency so the last write lands before done.
        if (drain_cnt_q == LAST_DRAIN) begin
          state_d = DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == FETCH) begin
      in_mem_addr_d = sample_idx_d;
    end
    res_en_d = (state_d == INJECT);
    if (res_en_d) begin
      res_din_d = mask_d[node_idx_d] ? sample_d
                : DATA_WIDTH'(sat_neg(64'(signed'(sample_d)), DATA_WIDTH));
    end
    // An empty run goes straight IDLE -> DONE and never reports busy.
    busy_d = (state_d != IDLE) && !(state_q == IDLE && state_d == DONE);
    done_d = (state_q == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sample_idx_q  <= '0;
      node_idx_q    <= '0;
      drain_cnt_q   <= '0;
      num_q         <= '0;
      mask_q        <= '0;
      sample_q      <= '0;
      in_mem_addr_q <= '0;
      res_en_q      <= 1'b0;
      res_din_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      wr_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      sample_idx_q  <= sample_idx_d;
      node_idx_q    <= node_idx_d;
      drain_cnt_q   <= drain_cnt_d;
      num_q         <= num_d;
      mask_q        <= mask_d;
      sample_q      <= sample_d;
      in_mem_addr_q <= in_mem_addr_d;
      res_en_q      <= res_en_d;
      res_din_q     <= res_din_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      wr_cnt_q      <= wr_cnt_d;
    end
  end

  // Align the reservoir strobe with the cycle its result is valid.
  pipe_delay #(
    .DEPTH(RES_LATENCY),
    .WIDTH(1)
  ) u_wen_dly (
    .clk(clk),
    .rst(rst),
    .d_i(res_en_q),
    .q_o(hist_wen_w)
  );

  assign busy          = busy_q;
  assign done          = done_q;
  assign in_mem_addr   = in_mem_addr_q;
  assign reservoir_din = res_din_q;
  assign reservoir_en  = res_en_q;
  assign hist_addr     = wr_cnt_q;
  assign hist_wen      = hist_wen_w;
  assign hist_din      = hist_wen_w ? reservoir_dout : '0;

endmodule

// File: tb/tb_reservoir_input_sequencer.sv
module tb_reservoir_input_sequencer;

  localparam int VN = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: RES_LATENCY=1
  logic        start_a, busy_a, done_a, ren_a, hwen_a;
  logic [13:0] num_a, in_addr_a, haddr_a;
  logic [9:0]  mask_a;
  logic [31:0] in_dout_a, rdin_a, rdout_a, hdin_a;
  // Instance B: RES_LATENCY=3
  logic        start_b, busy_b, done_b, ren_b, hwen_b;
  logic [13:0] num_b, in_addr_b, haddr_b;
  logic [9:0]  mask_b;
  logic [31:0] in_dout_b, rdin_b, rdout_b, hdin_b, rb1, rb2;

  logic [31:0] mem [16];

  reservoir_input_sequencer #(.ADDR_WIDTH(14), .DATA_WIDTH(32), .VIRTUAL_NODES(VN), .RES_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .num_samples(num_a), .mask(mask_a),
    .busy(busy_a), .done(done_a), .in_mem_addr(in_addr_a), .in_mem_dout(in_dout_a),
    .reservoir_din(rdin_a), .reservoir_en(ren_a), .reservoir_dout(rdout_a),
    .hist_addr(haddr_a), .hist_din(hdin_a), .hist_wen(hwen_a));

  reservoir_input_sequencer #(.ADDR_WIDTH(14), .DATA_WIDTH(32), .VIRTUAL_NODES(VN), .RES_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .num_samples(num_b), .mask(mask_b),
    .busy(busy_b), .done(done_b), .in_mem_addr(in_addr_b), .in_mem_dout(in_dout_b),
    .reservoir_din(rdin_b), .reservoir_en(ren_b), .reservoir_dout(rdout_b),
    .hist_addr(haddr_b), .hist_din(hdin_b), .hist_wen(hwen_b));

  // Synchronous-read input memories and identity reservoirs
  always @(posedge clk) begin
    in_dout_a <= mem[in_addr_a[3:0]];
    in_dout_b <= mem[in_addr_b[3:0]];
    rdout_a   <= rdin_a;
    rb1       <= rdin_b;
    rb2       <= rb1;
    rdout_b   <= rb2;
  end

  int n_checks = 0;
  int n_err    = 0;

  logic [63:0] exp_din_a [$];
  logic [63:0] exp_wr_a  [$];
  logic [63:0] exp_din_b [$];
  logic [63:0] exp_wr_b  [$];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] neg_exp(input logic [31:0] x);
    return (x == 32'h8000_0000) ? 32'h7FFF_FFFF : (~x + 32'd1);
  endfunction

  // Monitor: pop expected values whenever a DUT presents a strobe
  always @(negedge clk) begin
    if (ren_a) begin
      if (exp_din_a.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL din_a: unexpected reservoir_en, din=%0h", rdin_a);
      end else check("din_a", 64'(rdin_a), exp_din_a.pop_front());
    end
    if (hwen_a) begin
      if (exp_wr_a.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL wr_a: unexpected hist_wen, addr=%0d din=%0h", haddr_a, hdin_a);
      end else check("wr_a", 64'({haddr_a, hdin_a}), exp_wr_a.pop_front());
    end
    if (ren_b) begin
      if (exp_din_b.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL din_b: unexpected reservoir_en, din=%0h", rdin_b);
      end else check("din_b", 64'(rdin_b), exp_din_b.pop_front());
    end
    if (hwen_b) begin
      if (exp_wr_b.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL wr_b: unexpected hist_wen, addr=%0d din=%0h", haddr_b, hdin_b);
      end else check("wr_b", 64'({haddr_b, hdin_b}), exp_wr_b.pop_front());
    end
  end

  task automatic push_exp(input bit sel, input int n, input logic [9:0] m);
    logic [31:0] d;
    for (int s = 0; s < n; s++) begin
      for (int k = 0; k < VN; k++) begin
        d = m[k] ? mem[s] : neg_exp(mem[s]);
        if (sel) begin
          exp_din_b.push_back(64'(d));
          exp_wr_b.push_back(64'({14'(s * VN + k), d}));
        end else begin
          exp_din_a.push_back(64'(d));
          exp_wr_a.push_back(64'({14'(s * VN + k), d}));
        end
      end
    end
  endtask

  task automatic run(input bit sel, input int n, input logic [9:0] m, input bit disturb, input string tag);
    int cycles, exp_cycles, first_en, first_wen, rl, wr_left;
    bit busy_seen, dv;
    rl = sel ? 3 : 1;
    push_exp(sel, n, m);
    exp_cycles = (n == 0) ? 2 : 2 + n * (VN + 2) + rl;
    @(negedge clk);
    if (sel) begin num_b = 14'(n); mask_b = m; start_b = 1'b1; end
    else     begin num_a = 14'(n); mask_a = m; start_a = 1'b1; end
    cycles = 0; busy_seen = 0; first_en = -1; first_wen = -1; dv = 0;
    while (!dv && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin start_a = 1'b0; start_b = 1'b0; end
      dv = sel ? done_b : done_a;
      if (sel ? busy_b : busy_a) busy_seen = 1;
      if ((sel ? ren_b : ren_a) && first_en < 0) first_en = cycles;
      if ((sel ? hwen_b : hwen_a) && first_wen < 0) first_wen = cycles;
      if (disturb && cycles == 7) begin
        if (sel) begin start_b = 1'b1; mask_b = ~m; num_b = 14'd1; end
        else     begin start_a = 1'b1; mask_a = ~m; num_a = 14'd1; end
      end
      if (disturb && cycles == 8) begin start_a = 1'b0; start_b = 1'b0; end
    end
    wr_left = sel ? exp_wr_b.size() : exp_wr_a.size();
    check({tag, " cycles"}, 64'(cycles), 64'(exp_cycles));
    check({tag, " busy_seen"}, 64'(busy_seen), 64'(n != 0));
    check({tag, " writes_left_at_done"}, 64'(wr_left), 64'd0);
    if (n != 0) check({tag, " wen_lag"}, 64'(first_wen - first_en), 64'(rl));
    else        check({tag, " no_strobes"}, 64'(first_en < 0 && first_wen < 0), 64'd1);
  endtask

  task automatic reset_mid();
    int cycles;
    bit done_seen;
    for (int i = 0; i < 5; i++) mem[i] = 32'(10 + i);
    push_exp(1'b0, 5, 10'h3FF);
    @(negedge clk);
    num_a = 14'd5; mask_a = 10'h3FF; start_a = 1'b1;
    cycles = 0; done_seen = 0;
    while (cycles < 15) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) start_a = 1'b0;
      if (done_a) done_seen = 1;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid ctrl", 64'({busy_a, done_a, ren_a, hwen_a, in_addr_a, haddr_a}), 64'd0);
    check("rst_mid data", {rdin_a, hdin_a}, 64'd0);
    exp_din_a.delete();
    exp_wr_a.delete();
    repeat (30) begin
      @(negedge clk);
      if (done_a || busy_a) done_seen = 1;
    end
    check("rst_mid no_done_after", 64'(done_seen), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; num_a = '0; mask_a = '0;
    start_b = 1'b0; num_b = '0; mask_b = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("reset A ctrl", 64'({busy_a, done_a, ren_a, hwen_a, in_addr_a, haddr_a}), 64'd0);
    check("reset A data", {rdin_a, hdin_a}, 64'd0);
    check("reset B ctrl", 64'({busy_b, done_b, ren_b, hwen_b, in_addr_b, haddr_b}), 64'd0);
    rst = 1'b0;

    mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3;
    run(1'b0, 3, 10'h3FF, 1'b0, "basic");

    run(1'b0, 0, 10'h3FF, 1'b0, "zero");

    mem[0] = 32'd5; mem[1] = 32'h8000_0000;
    run(1'b0, 2, 10'b0101010101, 1'b0, "mask");

    mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3;
    run(1'b0, 3, 10'h3FF, 1'b1, "disturb");

    reset_mid();

    mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3;
    run(1'b0, 3, 10'h2AA, 1'b0, "restart");

    mem[0] = 32'd7; mem[1] = 32'hFFFF_FFF7;
    run(1'b1, 2, 10'b1100110011, 1'b0, "rl3");

    repeat (5) @(negedge clk);
    check("queues_empty", 64'(exp_din_a.size() + exp_wr_a.size() + exp_din_b.size() + exp_wr_b.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
